// File: rtl/rom_share_pkg.sv
// Shared definitions for the two-requester ROM port arbiter.
//   state_t    : arbiter FSM state encoding
//   DEF_ADDR_W : default ROM address width
//   DEF_DATA_W : default ROM data width
//   LAT_CNT_W  : width of the read-latency wait counter (holds 1..4)
package rom_share_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 8;
  localparam int LAT_CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rom_share_arbiter_if.sv
// Bundle of the requester handshake and the ROM port seen by the arbiter.
//   req0/addr0, req1/addr1 : requester read requests, held until ack
//   ack0/ack1/rdata        : one-cycle completion pulse and captured ROM word
//   busy                   : arbiter is not idle
//   rom_cs/rom_addr        : ROM enable and address
//   rom_dout               : ROM read data
// slave  : arbiter side
// master : client/ROM side
interface rom_share_arbiter_if
  import rom_share_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              rom_cs;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;

  modport slave (
    input  req0, addr0, req1, addr1, rom_dout,
    output ack0, ack1, rdata, busy, rom_cs, rom_addr
  );

  modport master (
    output req0, addr0, req1, addr1, rom_dout,
    input  ack0, ack1, rdata, busy, rom_cs, rom_addr
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector
//   update     : advance the pointer past the requester named by last
//   last       : index of the requester that was just served
//   gnt[1:0]   : one-hot grant (all zero when nobody requests)
// The pointer names the requester that wins a tie; it resets to 0.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       last,
  output logic [1:0] gnt
);

  logic ptr;

  // NOTE: every variable assigned in always_comb gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= ~last;
    end
  end

endmodule

// File: rtl/rom_share_arbiter.sv
// Shares one synchronous block ROM port between two requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester handshake + ROM port (slave modport)
// Parameters: ADDR_W, DATA_W, RD_LAT (ROM read latency, legal 1..4).
// Sequence per read: IDLE (grant) -> ISSUE (cs/addr to ROM) -> WAIT
// (count RD_LAT, capture data) -> DONE (one-cycle ack). With RD_LAT=1 a
// request seen in cycle 0 is acked in cycle 3.
module rom_share_arbiter
  import rom_share_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  rom_share_arbiter_if.slave  bus
);

  state_t               state;
  logic                 gnt_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [LAT_CNT_W-1:0] cnt;
  logic [DATA_W-1:0]    rdata_q;
  logic                 cs_q;
  logic                 ack0_q;
  logic                 ack1_q;
  logic                 busy_q;
  logic [1:0]           gnt;

  // The pointer moves to the other requester as the transaction finishes,
  // so two continuous requesters alternate.
  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({bus.req1, bus.req0}),
    .update (state == DONE),
    .last   (gnt_q),
    .gnt    (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      cs_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            gnt_q  <= gnt[1];
            addr_q <= gnt[1] ? bus.addr1 : bus.addr0;
            cs_q   <= 1'b1;
            busy_q <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= LAT_CNT_W'(RD_LAT);
          state <= WAIT;
        end
        WAIT: begin
          // cs stays high while waiting so a pipelined ROM keeps advancing.
          cnt <= cnt - LAT_CNT_W'(1);
          if (cnt == LAT_CNT_W'(1)) begin
            rdata_q <= bus.rom_dout;
            cs_q    <= 1'b0;
            ack0_q  <= ~gnt_q;
            ack1_q  <= gnt_q;
            state   <= DONE;
          end
        end
        DONE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The latched address drives the ROM directly; later addr changes from
  // the requester never reach it.
  assign bus.rom_addr = addr_q;
  assign bus.rom_cs   = cs_q;
  assign bus.rdata    = rdata_q;
  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_rom_share_arbiter.sv
// Self-checking bench for rom_share_arbiter. A timeline model predicts, from
// the requests seen while the arbiter is free, when each read is granted,
// when rom_cs/busy are high, which ack fires and what data it carries.
// A second instance built with RD_LAT=3 checks the longer read sequence.
module tb_rom_share_arbiter;
  import rom_share_pkg::*;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int L1 = 1;

  typedef struct {
    int             cyc;
    bit             idx;
    logic [DW-1:0]  data;
  } ack_rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rom_share_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  rom_share_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

  rom_share_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  rom_share_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  // Requester drive
  logic          req0, req1, r3_req0;
  logic [AW-1:0] addr0, addr1, r3_addr0;
  assign bus1.req0  = req0;
  assign bus1.addr0 = addr0;
  assign bus1.req1  = req1;
  assign bus1.addr1 = addr1;
  assign bus3.req0  = r3_req0;
  assign bus3.addr0 = r3_addr0;
  assign bus3.req1  = 1'b0;
  assign bus3.addr1 = '0;

  // ROM content: mem[i] = 8'hA0 + i
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return 8'hA0 + 8'(a);
  endfunction

  // ROM models: output pipeline advances only while cs is high.
  logic [DW-1:0] pipe1;
  logic [DW-1:0] pipe3 [3];
  always @(posedge clk) begin
    if (bus1.rom_cs) pipe1 <= rom_word(bus1.rom_addr);
  end
  always @(posedge clk) begin
    if (bus3.rom_cs) begin
      pipe3[0] <= rom_word(bus3.rom_addr);
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
    end
  end
  assign bus1.rom_dout = pipe1;
  assign bus3.rom_dout = pipe3[2];

  // Counters
  int total = 0;
  int bad = 0;

  // Timeline model state
  int            cyc;
  bit            act;
  int            g_cyc;
  bit            g_idx;
  logic [AW-1:0] g_addr;
  bit            ptr_m;
  logic [DW-1:0] rdata_m;
  int            last_ack0, last_ack1;
  ack_rec_t      ack_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare DUT outputs of the current cycle with the model; requesters
  // drop req on the ack edge.
  task automatic compare();
    bit in_cs, in_busy, is_ack;
    in_cs   = act && (cyc >= g_cyc + 1) && (cyc <= g_cyc + 1 + L1);
    in_busy = act && (cyc >= g_cyc + 1) && (cyc <= g_cyc + 2 + L1);
    is_ack  = act && (cyc == g_cyc + 2 + L1);
    if (is_ack) rdata_m = rom_word(g_addr);
    check("ack0", 32'(bus1.ack0), 32'(is_ack && !g_idx));
    check("ack1", 32'(bus1.ack1), 32'(is_ack && g_idx));
    check("ack_excl", 32'(bus1.ack0 & bus1.ack1), 32'd0);
    check("rom_cs", 32'(bus1.rom_cs), 32'(in_cs));
    check("busy", 32'(bus1.busy), 32'(in_busy));
    check("rdata", 32'(bus1.rdata), 32'(rdata_m));
    if (in_cs) check("rom_addr", 32'(bus1.rom_addr), 32'(g_addr));
    if (bus1.ack0 | bus1.ack1) ack_log.push_back('{cyc, bus1.ack1, bus1.rdata});
    if (bus1.ack0) begin req0 = 1'b0; last_ack0 = cyc; end
    if (bus1.ack1) begin req1 = 1'b0; last_ack1 = cyc; end
  endtask

  // Requests present in the current cycle are granted if the arbiter is free.
  task automatic commit();
    if (!(act && cyc <= g_cyc + 2 + L1) && (req0 || req1)) begin
      act    = 1'b1;
      g_cyc  = cyc;
      g_idx  = (req0 && req1) ? ptr_m : req1;
      g_addr = g_idx ? addr1 : addr0;
      ptr_m  = !g_idx;
    end
  endtask

  task automatic tick();
    commit();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic release_reset();
    req0 = 1'b0;
    req1 = 1'b0;
    r3_req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    act = 1'b0;
    ptr_m = 1'b0;
    rdata_m = '0;
    last_ack0 = -10;
    last_ack1 = -10;
    compare();
  endtask

  task automatic reset_dut();
    req0 = 1'b0;
    req1 = 1'b0;
    r3_req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  task automatic drive_random();
    if (!req0) begin
      if (cyc > last_ack0 + 1 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1;
        addr0 = AW'($urandom);
      end
    end else if ($urandom_range(0, 15) == 0) begin
      req0 = 1'b0;
    end else if ($urandom_range(0, 3) == 0) begin
      addr0 = AW'($urandom);
    end
    if (!req1) begin
      if (cyc > last_ack1 + 1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1;
        addr1 = AW'($urandom);
      end
    end else if ($urandom_range(0, 15) == 0) begin
      req1 = 1'b0;
    end else if ($urandom_range(0, 3) == 0) begin
      addr1 = AW'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    req0 = 1'b0; req1 = 1'b0; r3_req0 = 1'b0;
    addr0 = '0; addr1 = '0; r3_addr0 = '0;

    // Test 1: single read, ack in cycle 3
    reset_dut();
    check("t1_reset_cs", 32'(bus1.rom_cs), 32'd0);
    req0 = 1'b1; addr0 = 3'd5;
    tick();
    check("t1_cs_c1", 32'(bus1.rom_cs), 32'd1);
    check("t1_addr_c1", 32'(bus1.rom_addr), 32'd5);
    tick();
    check("t1_cs_c2", 32'(bus1.rom_cs), 32'd1);
    tick();
    check("t1_ack0_c3", 32'(bus1.ack0), 32'd1);
    check("t1_ack1_c3", 32'(bus1.ack1), 32'd0);
    check("t1_rdata", 32'(bus1.rdata), 32'hA5);
    tick();

    // Test 2: simultaneous requests, req0 wins, req1 acked 4 cycles later
    reset_dut();
    ack_log.delete();
    req0 = 1'b1; addr0 = 3'd2;
    req1 = 1'b1; addr1 = 3'd7;
    repeat (9) tick();
    check("t2_count", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() >= 2) begin
      check("t2_first_idx", 32'(ack_log[0].idx), 32'd0);
      check("t2_first_data", 32'(ack_log[0].data), 32'hA2);
      check("t2_second_idx", 32'(ack_log[1].idx), 32'd1);
      check("t2_second_data", 32'(ack_log[1].data), 32'hA7);
      check("t2_gap", 32'(ack_log[1].cyc - ack_log[0].cyc), 32'd4);
    end

    // Test 3: continuous requesters alternate with 4-cycle spacing
    reset_dut();
    ack_log.delete();
    req0 = 1'b1; addr0 = AW'($urandom);
    req1 = 1'b1; addr1 = AW'($urandom);
    repeat (32) begin
      tick();
      if (!req0 && cyc > last_ack0 + 1) begin req0 = 1'b1; addr0 = AW'($urandom); end
      if (!req1 && cyc > last_ack1 + 1) begin req1 = 1'b1; addr1 = AW'($urandom); end
    end
    check("t3_count", 32'(ack_log.size()), 32'd8);
    foreach (ack_log[i]) begin
      check("t3_alt", 32'(ack_log[i].idx), 32'(i % 2));
      if (i > 0) check("t3_gap", 32'(ack_log[i].cyc - ack_log[i-1].cyc), 32'd4);
    end

    // Test 4: address change after grant is ignored
    reset_dut();
    req0 = 1'b1; addr0 = 3'd3;
    tick();
    addr0 = 3'd6;
    tick();
    check("t4_rom_addr", 32'(bus1.rom_addr), 32'd3);
    tick();
    check("t4_ack0", 32'(bus1.ack0), 32'd1);
    check("t4_rdata", 32'(bus1.rdata), 32'hA3);
    tick();

    // Test 5: reset during WAIT aborts, then a fresh request completes
    req0 = 1'b1; addr0 = 3'd1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5_cs_rst", 32'(bus1.rom_cs), 32'd0);
    check("t5_busy_rst", 32'(bus1.busy), 32'd0);
    check("t5_rdata_rst", 32'(bus1.rdata), 32'd0);
    check("t5_ack_rst", 32'(bus1.ack0), 32'd0);
    req0 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t5_noack", 32'(bus1.ack0 | bus1.ack1), 32'd0);
    end
    release_reset();
    repeat (4) tick();
    req0 = 1'b1; addr0 = 3'd4;
    repeat (3) tick();
    check("t5_ack0", 32'(bus1.ack0), 32'd1);
    check("t5_rdata", 32'(bus1.rdata), 32'hA4);
    tick();

    // Randomized traffic against the timeline model
    reset_dut();
    repeat (400) begin
      drive_random();
      tick();
    end

    // Test 6: RD_LAT=3 instance, cs high cycles 1-4, ack in cycle 5
    reset_dut();
    r3_req0 = 1'b1; r3_addr0 = 3'd4;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check("t6_cs", 32'(bus3.rom_cs), 32'(c <= 4));
      check("t6_busy", 32'(bus3.busy), 32'(c <= 5));
      check("t6_ack0", 32'(bus3.ack0), 32'(c == 5));
      check("t6_ack1", 32'(bus3.ack1), 32'd0);
      if (c == 5) check("t6_rdata", 32'(bus3.rdata), 32'hA4);
      if (bus3.ack0) r3_req0 = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
